// File: rtl/drac_pkg.sv
// drac_pkg: core-side constants and types shared by the dcache request arbiter.
//   arb_state_t     drain FSM encoding (RUN, DRAIN, DONE)
//   DCACHE_NUM_REQ  number of dcache requesters (LSU, PTW, debug/flush)
//   DCACHE_TID_W    transaction tag width tracked by the arbiter
//   rr_wrap_inc     round-robin pointer advance with wrap
package drac_pkg;

    localparam int unsigned DCACHE_NUM_REQ      = 3;
    localparam int unsigned DCACHE_TID_W        = 7;
    localparam int unsigned DCACHE_MAX_INFLIGHT = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: request/response payload types of the HPDC core request port.
// Only the fields the request arbiter and its neighbours rely on are modelled:
// the arbiter rewrites sid and routes on tid, everything else passes through.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_PA_WIDTH          = 40;
    localparam int unsigned HPDCACHE_WORD_WIDTH        = 64;
    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 8;
    localparam int unsigned HPDCACHE_REQ_SRC_ID_WIDTH  = 3;

    typedef struct packed {
        logic [HPDCACHE_PA_WIDTH-1:0]           addr;
        logic [HPDCACHE_WORD_WIDTH-1:0]         wdata;
        logic [3:0]                             op;
        logic [HPDCACHE_WORD_WIDTH/8-1:0]       be;
        logic [2:0]                             size;
        logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   sid;
        logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] tid;
        logic                                   need_rsp;
        logic                                   uncacheable;
    } hpdcache_req_t;

    typedef struct packed {
        logic [HPDCACHE_WORD_WIDTH-1:0]         rdata;
        logic [HPDCACHE_REQ_SRC_ID_WIDTH-1:0]   sid;
        logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] tid;
        logic                                   error;
        logic                                   aborted;
    } hpdcache_rsp_t;

endpackage

// File: rtl/dcache_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first set bit of mask scanning upward from ptr, wrapping modulo N.
//   mask   candidate bitmap
//   ptr    index with highest priority this cycle
//   valid  at least one candidate
//   idx    index of the winning candidate (0 when valid=0)
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IDX_W'((32'(ptr) + off) % N);
            if (!valid && mask[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares the HPDC core request port between NUM_REQ
// requesters (0 = dcache_interface, then PTW, then debug/flush engine).
// Round-robin grant that only advances on an accepted request, a pending/owner
// table indexed by transaction tag that routes responses back to the issuer,
// and a drain FSM so fences/flushes can wait for zero transactions in flight.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   req_valid_i/req_i   per-requester request (tag in req_i[n].tid[TID_W-1:0])
//   req_ready_o         one-hot accept for the granted requester
//   core_req_valid_o    request valid towards HPDC
//   req_dcache_o        granted payload with sid replaced by requester index
//   dcache_ready_i      HPDC accepts the request
//   dcache_valid_i      HPDC response valid
//   rsp_dcache_i        HPDC response payload
//   rsp_valid_o         one-hot response valid to the owning requester
//   rsp_o               response payload broadcast to all requesters
//   drain_i             level request to stop granting and drain
//   drain_done_o        high while drained
//   inflight_o          outstanding transaction count
//
// Optional: define DCACHE_ARB_CHECK_EN to compile in simulation-only protocol
// checks (send on pending tag, response on idle tag, count over/underflow,
// unstable request while stalled); each is fatal.
module dcache_req_arbiter
    import drac_pkg::*;
    import hpdcache_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DCACHE_NUM_REQ,
    parameter int unsigned TID_W        = DCACHE_TID_W,
    parameter int unsigned MAX_INFLIGHT = DCACHE_MAX_INFLIGHT
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  hpdcache_req_t [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            core_req_valid_o,
    output hpdcache_req_t                   req_dcache_o,
    input  logic                            dcache_ready_i,
    input  logic                            dcache_valid_i,
    input  hpdcache_rsp_t                   rsp_dcache_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output hpdcache_rsp_t                   rsp_o,
    input  logic                            drain_i,
    output logic                            drain_done_o,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DEPTH = 2 ** TID_W;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [DEPTH-1:0] pending;
    logic [IDX_W-1:0] owner [DEPTH];
    logic [CNT_W-1:0] inflight;
    arb_state_t       state;
    arb_state_t       state_next;

    logic [NUM_REQ-1:0] eligible;
    logic               can_issue;
    logic               grant_valid;
    logic               send;
    logic               rsp_hit;
    logic [TID_W-1:0]   send_tid;
    logic [TID_W-1:0]   rsp_tid;

    // ------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------
    assign can_issue = (inflight < CNT_W'(MAX_INFLIGHT)) && (state == RUN);

    always_comb begin
        eligible = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            eligible[n] = req_valid_i[n] && !pending[req_i[n].tid[TID_W-1:0]] && can_issue;
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .mask  (eligible),
        .ptr   (rr_ptr),
        .valid (grant_valid),
        .idx   (winner)
    );

    always_comb begin
        req_dcache_o     = req_i[winner];
        req_dcache_o.sid = HPDCACHE_REQ_SRC_ID_WIDTH'(winner);
    end

    assign core_req_valid_o = grant_valid;
    assign send             = grant_valid && dcache_ready_i;
    assign send_tid         = req_dcache_o.tid[TID_W-1:0];

    always_comb begin
        req_ready_o = '0;
        if (send) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response routing; responses to idle tags are dropped
    // ------------------------------------------------------------------
    assign rsp_tid = rsp_dcache_i.tid[TID_W-1:0];
    assign rsp_hit = dcache_valid_i && pending[rsp_tid];
    assign rsp_o   = rsp_dcache_i;

    always_comb begin
        rsp_valid_o = '0;
        if (rsp_hit) begin
            rsp_valid_o[owner[rsp_tid]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State: pending table, round-robin pointer, in-flight count, FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending  <= '0;
            rr_ptr   <= '0;
            inflight <= '0;
            state    <= RUN;
        end else begin
            // A tag being answered is still pending, so it can never be the
            // tag being sent in the same cycle; clear and set never collide.
            if (rsp_hit) begin
                pending[rsp_tid] <= 1'b0;
            end
            if (send) begin
                pending[send_tid] <= 1'b1;
                rr_ptr            <= IDX_W'(rr_wrap_inc(32'(winner), NUM_REQ));
            end
            case ({send, rsp_hit})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned t = 0; t < DEPTH; t++) begin
                owner[t] <= '0;
            end
        end else if (send) begin
            owner[send_tid] <= winner;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (drain_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_i) begin
                    state_next = RUN;
                end else if ((inflight == '0) && !send) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!drain_i) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign drain_done_o = (state == DONE);
    assign inflight_o   = inflight;

`ifdef DCACHE_ARB_CHECK_EN
    logic             stalled_q;
    logic [IDX_W-1:0] stalled_idx_q;
    hpdcache_req_t    stalled_req_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stalled_q     <= 1'b0;
            stalled_idx_q <= '0;
            stalled_req_q <= '0;
        end else begin
            stalled_q     <= grant_valid && !dcache_ready_i;
            stalled_idx_q <= winner;
            stalled_req_q <= req_i[winner];

            if (send && pending[send_tid]) begin
                $display("dcache_req_arbiter: send on pending tid=%0h time=%0t", send_tid, $time);
                $fatal(1, "dcache_req_arbiter: send on pending tag");
            end
            if (dcache_valid_i && !pending[rsp_tid]) begin
                $display("dcache_req_arbiter: response on idle tid=%0h time=%0t", rsp_tid, $time);
                $fatal(1, "dcache_req_arbiter: response on idle tag");
            end
            if (send && !rsp_hit && (inflight == CNT_W'(MAX_INFLIGHT))) begin
                $display("dcache_req_arbiter: inflight overflow tid=%0h time=%0t", send_tid, $time);
                $fatal(1, "dcache_req_arbiter: inflight overflow");
            end
            if (rsp_hit && !send && (inflight == '0)) begin
                $display("dcache_req_arbiter: inflight underflow tid=%0h time=%0t", rsp_tid, $time);
                $fatal(1, "dcache_req_arbiter: inflight underflow");
            end
            if (stalled_q && (!req_valid_i[stalled_idx_q] || (req_i[stalled_idx_q] != stalled_req_q))) begin
                $display("dcache_req_arbiter: unstable stalled request tid=%0h time=%0t",
                         stalled_req_q.tid, $time);
                $fatal(1, "dcache_req_arbiter: requester changed request while stalled");
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter (NUM_REQ=3, TID_W=7, MAX_INFLIGHT=16).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dcache_req_arbiter;
    import hpdcache_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [2:0]            req_valid;
    hpdcache_req_t [2:0]   req;
    logic [2:0]            req_ready;
    logic                  core_req_valid;
    hpdcache_req_t         req_dcache;
    logic                  dcache_ready;
    logic                  dcache_valid;
    hpdcache_rsp_t         rsp_in;
    logic [2:0]            rsp_valid;
    hpdcache_rsp_t         rsp_out;
    logic                  drain;
    logic                  drain_done;
    logic [4:0]            inflight;

    int unsigned nerr = 0;
    int unsigned nchk = 0;

    always #5 clk = ~clk;

    dcache_req_arbiter #(
        .NUM_REQ      (3),
        .TID_W        (7),
        .MAX_INFLIGHT (16)
    ) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .req_valid_i      (req_valid),
        .req_i            (req),
        .req_ready_o      (req_ready),
        .core_req_valid_o (core_req_valid),
        .req_dcache_o     (req_dcache),
        .dcache_ready_i   (dcache_ready),
        .dcache_valid_i   (dcache_valid),
        .rsp_dcache_i     (rsp_in),
        .rsp_valid_o      (rsp_valid),
        .rsp_o            (rsp_out),
        .drain_i          (drain),
        .drain_done_o     (drain_done),
        .inflight_o       (inflight)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned n, input logic [7:0] tid, input logic [39:0] addr);
        hpdcache_req_t r;
        r          = '0;
        r.tid      = tid;
        r.addr     = addr;
        r.need_rsp = 1'b1;
        r.sid      = 3'd7;
        req[n]     = r;
    endtask

    task automatic drive_rsp(input logic v, input logic [7:0] tid);
        dcache_valid = v;
        rsp_in       = '0;
        rsp_in.tid   = tid;
        rsp_in.rdata = 64'hA000 + {56'h0, tid};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        req_valid    = '0;
        req          = '0;
        dcache_ready = 1'b0;
        drain        = 1'b0;
        drive_rsp(1'b1, 8'h05);

        // Reset state; a response during reset finds no pending tag
        repeat (2) @(negedge clk);
        #1;
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_core_valid", 64'(core_req_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_drain_done", 64'(drain_done), 64'd0);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        rstn = 1'b1;

        // 1: req0 and req2 together, rr_ptr=0
        @(negedge clk);
        dcache_ready = 1'b1;
        set_req(0, 8'h05, 40'h100);
        set_req(2, 8'h40, 40'h300);
        req_valid = 3'b101;
        #1;
        chk("t1_c0_valid", 64'(core_req_valid), 64'd1);
        chk("t1_c0_ready", 64'(req_ready), 64'b001);
        chk("t1_c0_sid", 64'(req_dcache.sid), 64'd0);
        chk("t1_c0_tid", 64'(req_dcache.tid), 64'h05);
        chk("t1_c0_inflight", 64'(inflight), 64'd0);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        chk("t1_c1_ready", 64'(req_ready), 64'b100);
        chk("t1_c1_sid", 64'(req_dcache.sid), 64'd2);
        chk("t1_c1_addr", 64'(req_dcache.addr), 64'h300);
        chk("t1_c1_inflight", 64'(inflight), 64'd1);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("t1_inflight2", 64'(inflight), 64'd2);
        chk("t1_idle_valid", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        drive_rsp(1'b1, 8'h05);
        #1;
        chk("t1_rsp05_valid", 64'(rsp_valid), 64'b001);
        chk("t1_rsp05_tid", 64'(rsp_out.tid), 64'h05);
        @(negedge clk);
        drive_rsp(1'b1, 8'h40);
        #1;
        chk("t1_rsp40_valid", 64'(rsp_valid), 64'b100);
        chk("t1_rsp40_inflight", 64'(inflight), 64'd1);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t1_end_inflight", 64'(inflight), 64'd0);
        chk("t1_end_rsp_valid", 64'(rsp_valid), 64'd0);

        // 2: tag collision between req1 and req0, rr_ptr=0
        @(negedge clk);
        set_req(1, 8'h10, 40'h110);
        req_valid = 3'b010;
        #1;
        chk("t2_req1_ready", 64'(req_ready), 64'b010);
        chk("t2_req1_sid", 64'(req_dcache.sid), 64'd1);
        @(negedge clk);
        set_req(0, 8'h10, 40'h120);
        req_valid = 3'b001;
        #1;
        chk("t2_blocked_valid", 64'(core_req_valid), 64'd0);
        chk("t2_blocked_ready", 64'(req_ready), 64'd0);
        chk("t2_blocked_inflight", 64'(inflight), 64'd1);
        @(negedge clk);
        #1;
        chk("t2_blocked2_valid", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        drive_rsp(1'b1, 8'h10);
        #1;
        chk("t2_rsp_valid", 64'(rsp_valid), 64'b010);
        chk("t2_rsp_cycle_blocked", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t2_req0_ready", 64'(req_ready), 64'b001);
        chk("t2_req0_sid", 64'(req_dcache.sid), 64'd0);
        chk("t2_req0_inflight", 64'(inflight), 64'd0);
        @(negedge clk);
        req_valid = 3'b000;
        drive_rsp(1'b1, 8'h10);
        #1;
        chk("t2_rsp_owner0", 64'(rsp_valid), 64'b001);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t2_end_inflight", 64'(inflight), 64'd0);

        // 3: HPDC stall with req0 and req1, rr_ptr=1
        @(negedge clk);
        dcache_ready = 1'b0;
        set_req(0, 8'h21, 40'h210);
        set_req(1, 8'h22, 40'h220);
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_stall_valid", 64'(core_req_valid), 64'd1);
            chk("t3_stall_ready", 64'(req_ready), 64'd0);
            chk("t3_stall_sid", 64'(req_dcache.sid), 64'd1);
            chk("t3_stall_addr", 64'(req_dcache.addr), 64'h220);
            @(negedge clk);
        end
        dcache_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(req_ready), 64'b010);
        chk("t3_release_tid", 64'(req_dcache.tid), 64'h22);
        @(negedge clk);
        req_valid = 3'b001;
        #1;
        chk("t3_next_ready", 64'(req_ready), 64'b001);
        chk("t3_next_tid", 64'(req_dcache.tid), 64'h21);
        chk("t3_next_inflight", 64'(inflight), 64'd1);
        @(negedge clk);
        req_valid = 3'b000;
        drive_rsp(1'b1, 8'h22);
        #1;
        chk("t3_rsp22", 64'(rsp_valid), 64'b010);
        chk("t3_inflight2", 64'(inflight), 64'd2);
        @(negedge clk);
        drive_rsp(1'b1, 8'h21);
        #1;
        chk("t3_rsp21", 64'(rsp_valid), 64'b001);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t3_end_inflight", 64'(inflight), 64'd0);

        // 4: saturate MAX_INFLIGHT from req2
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_req(2, 8'h50 + 8'(i), 40'h500 + 40'(i));
            req_valid = 3'b100;
            #1;
            chk("t4_fill_ready", 64'(req_ready), 64'b100);
        end
        @(negedge clk);
        set_req(2, 8'h60, 40'h600);
        #1;
        chk("t4_full_valid", 64'(core_req_valid), 64'd0);
        chk("t4_full_ready", 64'(req_ready), 64'd0);
        chk("t4_full_inflight", 64'(inflight), 64'd16);
        @(negedge clk);
        drive_rsp(1'b1, 8'h50);
        #1;
        chk("t4_free_rsp", 64'(rsp_valid), 64'b100);
        chk("t4_free_same_cycle", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t4_regrant_ready", 64'(req_ready), 64'b100);
        chk("t4_regrant_inflight", 64'(inflight), 64'd15);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("t4_refull_inflight", 64'(inflight), 64'd16);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            drive_rsp(1'b1, 8'h50 + 8'(i));
        end
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t4_end_inflight", 64'(inflight), 64'd0);

        // 5: drain with 3 in flight
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            set_req(1, 8'h30 + 8'(i), 40'h700 + 40'(i));
            req_valid = 3'b010;
            #1;
            chk("t5_fill_ready", 64'(req_ready), 64'b010);
        end
        @(negedge clk);
        req_valid = 3'b000;
        drain     = 1'b1;
        #1;
        chk("t5_drain_inflight", 64'(inflight), 64'd3);
        chk("t5_drain_done0", 64'(drain_done), 64'd0);
        @(negedge clk);
        set_req(0, 8'h34, 40'h340);
        req_valid = 3'b001;
        #1;
        chk("t5_drain_blocked", 64'(core_req_valid), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive_rsp(1'b1, 8'h30 + 8'(i));
            #1;
            chk("t5_drain_rsp", 64'(rsp_valid), 64'b010);
            chk("t5_drain_rsp_done", 64'(drain_done), 64'd0);
            chk("t5_drain_rsp_blocked", 64'(core_req_valid), 64'd0);
        end
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        #1;
        chk("t5_drained_inflight", 64'(inflight), 64'd0);
        chk("t5_drained_blocked", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_done", 64'(drain_done), 64'd1);
        chk("t5_done_blocked", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        drain = 1'b0;
        #1;
        chk("t5_done_hold", 64'(drain_done), 64'd1);
        chk("t5_done_hold_blocked", 64'(core_req_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("t5_run_done", 64'(drain_done), 64'd0);
        chk("t5_run_ready", 64'(req_ready), 64'b001);
        chk("t5_run_tid", 64'(req_dcache.tid), 64'h34);
        @(negedge clk);
        req_valid = 3'b000;
        drive_rsp(1'b1, 8'h34);
        #1;
        chk("t5_rsp34", 64'(rsp_valid), 64'b001);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);

        // 5b: drain aborted before completion
        drain = 1'b1;
        #1;
        chk("t5b_inflight", 64'(inflight), 64'd0);
        @(negedge clk);
        drain = 1'b0;
        set_req(0, 8'h35, 40'h350);
        req_valid = 3'b001;
        #1;
        chk("t5b_drain_blocked", 64'(core_req_valid), 64'd0);
        chk("t5b_no_done", 64'(drain_done), 64'd0);
        @(negedge clk);
        #1;
        chk("t5b_resume_ready", 64'(req_ready), 64'b001);
        chk("t5b_resume_done", 64'(drain_done), 64'd0);
        @(negedge clk);
        req_valid = 3'b000;
        drive_rsp(1'b1, 8'h35);
        #1;
        chk("t5b_rsp35", 64'(rsp_valid), 64'b001);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);

        // 6: reset with 5 in flight, then a stale response
        for (int i = 1; i <= 5; i++) begin
            set_req(0, 8'(i), 40'h800 + 40'(i));
            req_valid = 3'b001;
            #1;
            chk("t6_fill_ready", 64'(req_ready), 64'b001);
            @(negedge clk);
        end
        req_valid = 3'b000;
        #1;
        chk("t6_inflight5", 64'(inflight), 64'd5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("t6_async_inflight", 64'(inflight), 64'd0);
        chk("t6_async_done", 64'(drain_done), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive_rsp(1'b1, 8'h03);
        #1;
        chk("t6_stale_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        drive_rsp(1'b0, 8'h00);
        set_req(0, 8'h03, 40'h803);
        req_valid = 3'b001;
        #1;
        chk("t6_stale_inflight", 64'(inflight), 64'd0);
        chk("t6_resend_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("t6_resend_inflight", 64'(inflight), 64'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
Shares the single HPDC core request port between NUM_REQ requesters: the load/store interface, the page-table walker and the debug/flush engine.
- Round-robin grant; the grant moves only on an accepted request.
- Tracks every outstanding transaction tag, records which requester owns it, and routes each response back to that owner.
- Provides a drain sequence so a fence/flush can wait until the cache has answered everything in flight.

Parameters:
NUM_REQ, 3, number of requesters (2..4); index 0 is the core dcache_interface.
TID_W, 7, transaction tag width; pending table depth is 2**TID_W.
MAX_INFLIGHT, 16, maximum outstanding transactions across all requesters.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_i  in  NUM_REQ x hpdcache_req_t  per-requester request payload (tid in req_i[n].tid[TID_W-1:0])
req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
core_req_valid_o  out  1  valid to HPDC
req_dcache_o  out  hpdcache_req_t  muxed payload, sid overwritten with requester index
dcache_ready_i  in  1  HPDC ready
dcache_valid_i  in  1  HPDC response valid
rsp_dcache_i  in  hpdcache_rsp_t  HPDC response
rsp_valid_o  out  NUM_REQ  one-hot response valid to the owning requester
rsp_o  out  hpdcache_rsp_t  response payload, broadcast to all requesters
drain_i  in  1  level request: stop granting and wait for zero in flight
drain_done_o  out  1  high while drained (DONE state)
inflight_o  out  5  outstanding transaction count (clog2(MAX_INFLIGHT)+1)

Behaviour:
Reset values:
- rr_ptr=0, pending table all IDLE, owner table 0, inflight_o=0, FSM=RUN.
- All outputs 0; req_dcache_o payload is don't-care with valid=0.

Eligibility and grant:
- Requester n is eligible iff req_valid_i[n] && !pending[req_i[n].tid] && inflight_o<MAX_INFLIGHT && FSM==RUN.
- Winner = first eligible index scanning from rr_ptr upward, wrapping modulo NUM_REQ.
- core_req_valid_o = any eligible; req_dcache_o = req_i[winner] with sid={winner}.
- Purely combinational, zero-latency forward path.

Handshake:
- send = core_req_valid_o && dcache_ready_i.
- req_ready_o[winner] = send; all other bits 0.
- On send: pending[tid]<=PENDING, owner[tid]<=winner, rr_ptr<=winner+1 (wraps to 0).
- No send means rr_ptr holds, so the grant stays stable while HPDC stalls.
- Requesters must hold valid and payload until ready.

Responses:
- On dcache_valid_i: rsp_valid_o[owner[rsp.tid]]=1 in the same cycle; rsp_o=rsp_dcache_i.
- pending[rsp.tid]<=IDLE.
- A response for an IDLE tag is dropped and rsp_valid_o stays 0.

Counter:
- inflight <= inflight + send - (dcache_valid_i && pending[rsp.tid]).
- Simultaneous send and response leaves the count unchanged.
- Response and re-send of the same tid in one cycle are impossible: the tag is still pending that cycle, so it is ineligible. It becomes eligible the next cycle.

Drain FSM (RUN, DRAIN, DONE):
- RUN -> DRAIN when drain_i=1. Grants are blocked from the next cycle onward; a request being sent in the same cycle completes.
- DRAIN -> DONE when inflight==0 and there is no send.
- DONE: drain_done_o=1 while drain_i remains high. DONE -> RUN when drain_i=0.
- DRAIN -> RUN if drain_i drops before completion (abort, no done pulse).
- If inflight is already 0 when drain_i rises: DONE follows DRAIN after one cycle.

Reset mid-operation: everything clears asynchronously. Late responses for the old tags are dropped as IDLE-tag responses.

Optional Feature:
DCACHE_ARB_CHECK_EN: compiles in simulation checks. With it, each of these is a fatal error with a $display of tid and time:
- send on a PENDING tag;
- response on an IDLE tag;
- inflight overflow or underflow;
- requester dropping valid or changing payload while stalled.

Without it: no checks; IDLE-tag responses are silently dropped.

Decomposition:
- drac_pkg gains arb_state_t {RUN, DRAIN, DONE}, DCACHE_NUM_REQ and DCACHE_TID_W constants.
- hpdcache_req_t and hpdcache_rsp_t come from hpdcache_pkg.
- One sub-module: rr_arbiter (parameterised round-robin priority pick from a mask and pointer, combinational), reusable elsewhere.

Test Plan:
1. Req0 and req2 valid (tids 0x05, 0x40), dcache_ready_i=1 -> req0 granted cycle 0, req2 cycle 1; sid 0 then 2; inflight 1 then 2.
2. Req1 sends tid 0x10; req0 then presents tid 0x10 -> req0 blocked until the 0x10 response. Response pulses rsp_valid_o=3'b010; req0 is granted the next cycle.
3. dcache_ready_i=0 for 4 cycles with req0 and req1 valid -> winner and rr_ptr unchanged; req_ready_o=0; payload stable.
4. Saturate 16 in flight -> core_req_valid_o=0 with requests pending; one response frees a slot -> grant the next cycle.
5. drain_i with 3 in flight -> no grants; drain_done_o rises the cycle after the third response. Drop drain_i -> RUN, grants resume.
6. Assert rstn_i with 5 in flight, then release and replay a response tid -> rsp_valid_o=0; with DCACHE_ARB_CHECK_EN the simulation fails fatally.
